exe_stage: RTL



---
 rtl/exe_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// Execute stage of the 16-bit pipeline: operand forwarding, ALU, branch resolution
// and the EX/MEM pipeline register, all updated on the falling clock edge.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        exKeep,
  input  logic        exClear,
  input  logic [15:0] rdata1_in,
  input  logic [15:0] rdata2_in,
  input  logic [15:0] imme_in,
  input  logic [15:0] pc_in,
  input  logic [3:0]  wreg_in,
  input  logic [3:0]  rreg1_in,
  input  logic [3:0]  rreg2_in,
  input  logic [3:0]  aluop_in,
  input  logic [1:0]  controlb_in,
  input  logic        ifjump_in,
  input  logic [1:0]  jorb_in,
  input  logic [1:0]  controlmem_in,
  input  logic        controlwb_in,
  input  logic [3:0]  memwb_wreg,
  input  logic        memwb_we,
  input  logic [15:0] memwb_wdata,
  output logic [15:0] alu_result_out,
  output logic [15:0] store_data_out,
  output logic [3:0]  wreg_out,
  output logic [1:0]  controlmem_out,
  output logic        controlwb_out,
  output logic        branch_taken,
  output logic [15:0] branch_target,
  output logic        load_use_hazard
);

  localparam logic [3:0] REG_NONE = 4'b1111;
  localparam logic [1:0] MEM_READ = 2'b00;
  localparam logic [1:0] MEM_NONE = 2'b11;

  logic [15:0] r_alu;
  logic [15:0] r_store;
  logic [3:0]  r_wreg;
  logic [1:0]  r_mem;
  logic        r_wb;

  logic        w_exmem_fwd_ok;
  logic [15:0] w_a;
  logic [15:0] w_rd2;
  logic [15:0] w_b;
  logic [15:0] w_alu;
  logic [1:0]  w_mem_norm;

  // A load in EX/MEM has no data yet, so it never forwards; the hazard unit stalls instead.
  assign w_exmem_fwd_ok = (r_wb == 1'b0) && (r_mem != MEM_READ);

  always_comb begin
    w_a = rdata1_in;
    if (rreg1_in != REG_NONE && rreg1_in == r_wreg && w_exmem_fwd_ok)
      w_a = r_alu;
    else if (rreg1_in != REG_NONE && rreg1_in == memwb_wreg && memwb_we)
      w_a = memwb_wdata;
  end

  always_comb begin
    w_rd2 = rdata2_in;
    if (rreg2_in != REG_NONE && rreg2_in == r_wreg && w_exmem_fwd_ok)
      w_rd2 = r_alu;
    else if (rreg2_in != REG_NONE && rreg2_in == memwb_wreg && memwb_we)
      w_rd2 = memwb_wdata;
  end

  always_comb begin
    unique case (controlb_in)
      2'b00:   w_b = w_rd2;
      2'b01:   w_b = imme_in;
      2'b10:   w_b = '0;
      default: w_b = pc_in;
    endcase
  end

  always_comb begin
    unique case (aluop_in)
      4'b0000: w_alu = w_a + w_b;
      4'b0010: w_alu = w_a - w_b;
      4'b0011: w_alu = w_a & w_b;
      4'b0100: w_alu = w_a | w_b;
      4'b0101: w_alu = w_a ^ w_b;
      4'b0110: w_alu = ~w_a;
      4'b0111: w_alu = w_a << w_b[3:0];
      4'b1000: w_alu = w_a >> w_b[3:0];
      4'b1001: w_alu = $signed(w_a) >>> w_b[3:0];
      4'b1010: w_alu = ($signed(w_a) < $signed(w_b)) ? 16'd1 : 16'd0;
      4'b1011: w_alu = (w_a < w_b) ? 16'd1 : 16'd0;
      4'b1100: w_alu = w_b;
      4'b1101: w_alu = w_a;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    branch_taken  = 1'b0;
    branch_target = pc_in;
    if (!ifjump_in) begin
      unique case (jorb_in)
        2'b00: branch_taken = (w_a == 16'd0);
        2'b01: branch_taken = (w_a != 16'd0);
        2'b10: branch_taken = 1'b1;
        default: branch_taken = 1'b0;
      endcase
      if (branch_taken)
        branch_target = (jorb_in == 2'b10) ? w_a : pc_in + imme_in;
    end
  end

  assign load_use_hazard = (r_mem == MEM_READ) && (r_wb == 1'b0) && (r_wreg != REG_NONE) &&
                           ((r_wreg == rreg1_in) || (r_wreg == rreg2_in));

  assign w_mem_norm = (controlmem_in == 2'b10) ? MEM_NONE : controlmem_in;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_alu   <= '0;
      r_store <= '0;
      r_wreg  <= REG_NONE;
      r_mem   <= MEM_NONE;
      r_wb    <= 1'b1;
    end else if (exKeep) begin
      r_alu   <= r_alu;
      r_store <= r_store;
      r_wreg  <= r_wreg;
      r_mem   <= r_mem;
      r_wb    <= r_wb;
    end else if (exClear) begin
      r_alu   <= '0;
      r_store <= '0;
      r_wreg  <= REG_NONE;
      r_mem   <= MEM_NONE;
      r_wb    <= 1'b1;
    end else begin
      r_alu   <= w_alu;
      r_store <= w_rd2;
      r_wreg  <= wreg_in;
      r_mem   <= w_mem_norm;
      r_wb    <= controlwb_in;
    end
  end

  assign alu_result_out = r_alu;
  assign store_data_out = r_store;
  assign wreg_out       = r_wreg;
  assign controlmem_out = r_mem;
  assign controlwb_out  = r_wb;

endmodule
